// File: rtl/oled_refresh_scheduler_if.sv
// oled_refresh_scheduler_if: bus between the refresh scheduler and the single IIC write engine.
interface oled_refresh_scheduler_if;
   logic        iic_start;
   logic [23:0] iic_data;
   logic        write_done;
   modport master (output iic_start, iic_data, input write_done);
   modport slave  (input iic_start, iic_data, output write_done);
endinterface

// File: rtl/oled_refresh_scheduler.sv
// oled_refresh_scheduler: grants the IIC write engine to init/clear/static/live generators in turn,
// schedules live redraws and recovers a hung bus with a per-write watchdog.
module oled_refresh_scheduler #(
   parameter int POWERUP_CYCLES = 5_000_000,
   parameter int REFRESH_CYCLES = 50_000_000,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic [23:0] init_data,
   input  logic        init_finish,
   input  logic [23:0] clear_data,
   input  logic        clear_finish,
   input  logic [23:0] static_data,
   input  logic        static_finish,
   input  logic [23:0] show_data,
   input  logic        show_finish,
   input  logic        data_updated,
   input  logic        force_redraw,
   oled_refresh_scheduler_if.master iic,
   output logic        init_req,
   output logic        clear_req,
   output logic        static_req,
   output logic        show_req,
   output logic        blk_clr,
   output logic        oled_ready,
   output logic        timeout_err,
   output logic [7:0]  err_cnt
);
   localparam int PW = $clog2(POWERUP_CYCLES + 1);
   localparam int RW = $clog2(REFRESH_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [2:0] {PWRUP, INIT, CLEAR, STATIC, SHOW, IDLE, RECOVER} state_t;
   state_t        state, state_n;
   logic [PW-1:0] pw_cnt;
   logic [RW-1:0] rf_cnt;
   logic [TW-1:0] wd_cnt;
   logic          busy, show_pend, full_pend;
   logic          writing, fin, done, expire, timeout, start_n, consume;
   always_comb begin
      writing = state inside {INIT, CLEAR, STATIC, SHOW};
      fin = state == INIT ? init_finish : state == CLEAR ? clear_finish :
            state == STATIC ? static_finish : show_finish;
      done = writing && iic.write_done;
      expire = state == IDLE && rf_cnt == RW'(REFRESH_CYCLES - 1);
      timeout = writing && busy && !iic.write_done && wd_cnt == TW'(TIMEOUT_CYCLES - 1);
      state_n = state;
      case (state)
         PWRUP:   state_n = pw_cnt == PW'(POWERUP_CYCLES - 1) ? INIT : PWRUP;
         INIT:    state_n = done && fin ? CLEAR : INIT;
         CLEAR:   state_n = done && fin ? STATIC : CLEAR;
         STATIC:  state_n = done && fin ? SHOW : STATIC;
         SHOW:    state_n = done && fin ? IDLE : SHOW;
         IDLE:    state_n = full_pend ? CLEAR : (show_pend || expire) ? SHOW : IDLE;
         default: state_n = INIT;
      endcase
      if (timeout) state_n = RECOVER;
      consume = state == IDLE && state_n != IDLE;
      // a write launches on entry to a write state, or one cycle after a non-final write_done
      start_n = (state_n != state && state_n inside {INIT, CLEAR, STATIC, SHOW}) || (done && !fin);
   end
   assign init_req = state == INIT;
   assign clear_req = state == CLEAR;
   assign static_req = state == STATIC;
   assign show_req = state == SHOW;
   assign iic.iic_data = init_req ? init_data : clear_req ? clear_data :
                         static_req ? static_data : show_req ? show_data : 24'd0;
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state <= PWRUP;
         pw_cnt <= '0;
         rf_cnt <= '0;
         wd_cnt <= '0;
         busy <= 1'b0;
         show_pend <= 1'b0;
         full_pend <= 1'b0;
         iic.iic_start <= 1'b0;
         blk_clr <= 1'b0;
         timeout_err <= 1'b0;
         oled_ready <= 1'b0;
         err_cnt <= '0;
      end else begin
         state <= state_n;
         pw_cnt <= state == PWRUP ? pw_cnt + 1'b1 : '0;
         rf_cnt <= state == IDLE && !expire ? rf_cnt + 1'b1 : '0;
         wd_cnt <= start_n ? '0 : busy ? wd_cnt + 1'b1 : wd_cnt;
         busy <= start_n || (busy && !iic.write_done && !timeout);
         show_pend <= data_updated || (show_pend && !consume);
         full_pend <= (force_redraw && !(state inside {PWRUP, RECOVER})) || (full_pend && !consume);
         iic.iic_start <= start_n;
         blk_clr <= timeout;
         timeout_err <= timeout;
         err_cnt <= timeout && err_cnt != 8'hff ? err_cnt + 8'd1 : err_cnt;
         oled_ready <= oled_ready || (state == SHOW && state_n == IDLE);
      end
   end
endmodule

// File: tb/tb_oled_refresh_scheduler.sv
// tb_oled_refresh_scheduler: model generators and IIC engine around the scheduler; every launched
// write is scored against a queue of expected (generator, index) writes.
module tb_oled_refresh_scheduler;
   localparam int N = 2;
   logic        sys_clk = 1'b0;
   logic        rst = 1'b1;
   logic        data_updated = 1'b0, force_redraw = 1'b0, hang = 1'b0;
   logic        init_req, clear_req, static_req, show_req, blk_clr, oled_ready, timeout_err;
   logic [7:0]  err_cnt;
   logic [23:0] init_data, clear_data, static_data, show_data;
   logic        init_finish, clear_finish, static_finish, show_finish;
   logic [7:0]  gidx [4];
   logic [3:0]  reqv;
   int          checks = 0, errors = 0, lat = 3, cd = 0, n, kind;
   typedef struct {int g; int i;} exp_t;
   exp_t        sb[$];
   exp_t        m_e;

   oled_refresh_scheduler_if iic ();

   oled_refresh_scheduler #(.POWERUP_CYCLES(4), .REFRESH_CYCLES(20), .TIMEOUT_CYCLES(10)) dut (
      .sys_clk(sys_clk), .rst(rst),
      .init_data(init_data), .init_finish(init_finish),
      .clear_data(clear_data), .clear_finish(clear_finish),
      .static_data(static_data), .static_finish(static_finish),
      .show_data(show_data), .show_finish(show_finish),
      .data_updated(data_updated), .force_redraw(force_redraw),
      .iic(iic),
      .init_req(init_req), .clear_req(clear_req), .static_req(static_req), .show_req(show_req),
      .blk_clr(blk_clr), .oled_ready(oled_ready), .timeout_err(timeout_err), .err_cnt(err_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic logic [23:0] word(int g, int i);
      return {8'h78, 8'((g + 1) * 16), 8'(160 + i)};
   endfunction

   assign reqv = {show_req, static_req, clear_req, init_req};
   assign init_data = word(0, int'(gidx[0]));
   assign clear_data = word(1, int'(gidx[1]));
   assign static_data = word(2, int'(gidx[2]));
   assign show_data = word(3, int'(gidx[3]));
   assign init_finish = iic.write_done && init_req && gidx[0] == 8'(N - 1);
   assign clear_finish = iic.write_done && clear_req && gidx[1] == 8'(N - 1);
   assign static_finish = iic.write_done && static_req && gidx[2] == 8'(N - 1);
   assign show_finish = iic.write_done && show_req && gidx[3] == 8'(N - 1);

   // generators: advance on write_done while granted, wrap after the last word
   always @(posedge sys_clk)
      for (int g = 0; g < 4; g++)
         gidx[g] <= (rst || blk_clr) ? 8'd0 :
                    (reqv[g] && iic.write_done) ? (gidx[g] == 8'(N - 1) ? 8'd0 : gidx[g] + 8'd1) : gidx[g];

   // engine: write_done is sampled lat edges after the edge that raised iic_start
   initial begin
      iic.write_done = 1'b0;
      forever begin
         @(posedge sys_clk); #1;
         iic.write_done = 1'b0;
         if (iic.iic_start && !hang) cd = lat;
         if (cd > 0) begin
            cd--;
            iic.write_done = cd == 0;
         end
      end
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge sys_clk)
      if (!rst && iic.iic_start) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra: got start data=%h req=%b, expected no write", iic.iic_data, reqv);
         end else begin
            m_e = sb.pop_front();
            check("sb_data", iic.iic_data, word(m_e.g, m_e.i));
            check("sb_req", reqv, 32'(1) << m_e.g);
         end
      end

   function automatic logic sig(int k);
      case (k)
         0:       return iic.iic_start;
         1, 2, 3, 4: return reqv[k - 1];
         5:       return timeout_err;
         6:       return |reqv;
         7:       return iic.write_done && show_finish;
         default: return sb.size() == 0;
      endcase
   endfunction

   task automatic wait_for(string name, int k, logic v, int budget, output int cnt);
      cnt = 0;
      while (sig(k) !== v) begin
         if (cnt == budget) begin
            checks++;
            errors++;
            $display("FAIL %s: got timeout after %0d cycles, expected signal %0d == %0b", name, cnt, k, v);
            return;
         end
         @(posedge sys_clk); #2;
         cnt++;
      end
   endtask

   task automatic step(int c);
      repeat (c) begin
         @(posedge sys_clk); #2;
      end
   endtask

   task automatic pulse(logic du, logic fr);
      data_updated = du;
      force_redraw = fr;
      step(1);
      data_updated = 1'b0;
      force_redraw = 1'b0;
   endtask

   task automatic push_pass(int g);
      for (int i = 0; i < N; i++) sb.push_back('{g, i});
   endtask

   task automatic quiet(string name, int c);
      int act = 0;
      repeat (c) begin
         step(1);
         if (|reqv || iic.iic_start) act++;
      end
      check(name, act, 0);
   endtask

   task automatic check_reset(string tag);
      check({tag, "_req"}, reqv, 0);
      check({tag, "_blk_clr"}, blk_clr, 0);
      check({tag, "_start"}, iic.iic_start, 0);
      check({tag, "_data"}, iic.iic_data, 0);
      check({tag, "_ready"}, oled_ready, 0);
      check({tag, "_timeout"}, timeout_err, 0);
      check({tag, "_err_cnt"}, err_cnt, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, expected finish before 2000000");
      $fatal(1, "simulation hung");
   end

   initial begin
      step(3);
      check_reset("por");
      rst = 1'b0;
      for (int g = 0; g < 4; g++) push_pass(g);
      wait_for("first_start", 0, 1'b1, 20, n);
      check("first_start_cycles", n, 4);
      check("first_start_req", reqv, 4'b0001);
      wait_for("frame_done", 7, 1'b1, 200, n);
      check("ready_before", oled_ready, 0);
      step(1);
      check("ready_after", oled_ready, 1);
      check("idle_req", reqv, 0);
      check("frame_sb_empty", sb.size(), 0);
      push_pass(3);
      wait_for("refresh", 4, 1'b1, 40, n);
      check("refresh_cycles", n, 20);
      check("refresh_req", reqv, 4'b1000);
      push_pass(3);
      step(1);
      pulse(1'b1, 1'b0);
      wait_for("show1_done", 7, 1'b1, 40, n);
      step(1);
      check("gap_idle", reqv, 0);
      step(1);
      check("reshow", reqv, 4'b1000);
      wait_for("show2_done", 7, 1'b1, 40, n);
      step(1);
      quiet("no_third_show", 8);
      check("show_sb_empty", sb.size(), 0);
      iic.write_done = 1'b1;
      quiet("idle_write_done", 4);
      push_pass(1);
      push_pass(2);
      push_pass(3);
      pulse(1'b1, 1'b1);
      wait_for("full_done", 7, 1'b1, 100, n);
      step(1);
      check("full_idle", reqv, 0);
      quiet("no_extra_show", 8);
      check("full_sb_empty", sb.size(), 0);
      for (int it = 0; it < 12; it++) begin
         kind = int'($urandom_range(0, 3));
         lat = int'($urandom_range(1, 4));
         step(int'($urandom_range(0, 5)));
         if (kind != 0) begin
            push_pass(1);
            push_pass(2);
         end
         push_pass(3);
         if (kind == 3) push_pass(3);
         pulse(kind == 0 || kind == 2, kind != 0);
         if (kind == 3) begin
            wait_for("rnd_clear", 2, 1'b1, 10, n);
            pulse(1'b1, 1'b0);
         end
         wait_for("rnd_drain", 8, 1'b1, 300, n);
         wait_for("rnd_idle", 6, 1'b0, 40, n);
      end
      check("rnd_sb_empty", sb.size(), 0);
      lat = 3;
      hang = 1'b1;
      sb.push_back('{3, 0});
      pulse(1'b1, 1'b0);
      wait_for("wd_start", 0, 1'b1, 5, n);
      wait_for("wd_fire", 5, 1'b1, 30, n);
      check("wd_cycles", n, 10);
      check("wd_blk_clr", blk_clr, 1);
      check("wd_err_cnt", err_cnt, 1);
      check("wd_req", reqv, 0);
      check("wd_ready", oled_ready, 1);
      sb.push_back('{0, 0});
      step(1);
      check("recover_init", reqv, 4'b0001);
      check("recover_pulse", timeout_err, 0);
      for (int t = 2; t <= 256; t++) begin
         wait_for("wd_loop", 5, 1'b1, 30, n);
         check("wd_sat", err_cnt, t > 255 ? 255 : t);
         if (t == 256) hang = 1'b0;
         sb.push_back('{0, 0});
         step(1);
      end
      sb.push_back('{0, 1});
      push_pass(1);
      push_pass(2);
      push_pass(3);
      wait_for("wd_recover_frame", 7, 1'b1, 200, n);
      step(1);
      check("wd_final_err", err_cnt, 255);
      check("wd_final_ready", oled_ready, 1);
      check("wd_sb_empty", sb.size(), 0);
      push_pass(1);
      sb.push_back('{2, 0});
      pulse(1'b0, 1'b1);
      wait_for("to_static", 3, 1'b1, 100, n);
      step(1);
      rst = 1'b1;
      step(1);
      check_reset("mid");
      rst = 1'b0;
      cd = 0;
      sb.delete();
      for (int g = 0; g < 4; g++) push_pass(g);
      wait_for("rst_first_start", 0, 1'b1, 20, n);
      check("rst_first_cycles", n, 4);
      check("rst_ready_low", oled_ready, 0);
      wait_for("rst_frame_done", 7, 1'b1, 200, n);
      step(1);
      check("rst_ready_high", oled_ready, 1);
      check("rst_sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
